// File: rtl/hand_pkg.sv
// hand_pkg: state and result encodings shared by the hand evaluator.
package hand_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRAW  = 3'd1,
        CLEAR = 3'd2,
        OVER  = 3'd3,
        SHORT = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        RES_NONE  = 2'b00,
        RES_SHORT = 2'b01,
        RES_CLEAR = 2'b10,
        RES_OVER  = 2'b11
    } result_t;
endpackage

// File: rtl/hand_score.sv
// hand_score: combinational scorer (hard sum plus optional soft ace, enabled by SOFT_ACE_EN).
module hand_score
    import hand_pkg::*;
#(
    parameter int SUM_W  = 7,
    parameter int TARGET = 18
) (
    input  logic [SUM_W-1:0] hard,
    input  logic             ace,
    output logic [SUM_W-1:0] score
);
`ifdef SOFT_ACE_EN
    logic [SUM_W-1:0] soft;
    assign soft  = hard + SUM_W'(10);
    assign score = (ace && soft <= SUM_W'(TARGET)) ? soft : hard;
`else
    logic unused_ace;
    assign unused_ace = ace;
    assign score      = hard;
`endif
endmodule

// File: rtl/hand_evaluator.sv
// hand_evaluator: card-by-card hand scorer classifying CLEAR/OVER/SHORT against TARGET.
// Optional soft-ace scoring is enabled by defining SOFT_ACE_EN.
module hand_evaluator
    import hand_pkg::*;
#(
    parameter int CARD_W    = 4,
    parameter int MAX_CARDS = 4,
    parameter int TARGET    = 18,
    parameter int SUM_W     = 7
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           card_valid,
    input  logic [CARD_W-1:0]              card_value,
    input  logic                           stand,
    output logic                           card_ready,
    output logic [2:0]                     cstate,
    output logic [SUM_W-1:0]               sum,
    output logic [$clog2(MAX_CARDS+1)-1:0] card_count,
    output logic                           done,
    output logic [1:0]                     result
);
    localparam int CNT_W = $clog2(MAX_CARDS+1);

    if ((2 ** SUM_W) <= TARGET + (2 ** CARD_W) + 10) begin : g_sum_w_check
        $error("SUM_W too narrow for TARGET and CARD_W");
    end

    state_t           st, st_nxt;
    result_t          res, res_nxt;
    logic [SUM_W-1:0] hard, hard_nxt, s_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             accept, ace_nxt;

    assign card_ready = (st == DRAW) && (card_count < CNT_W'(MAX_CARDS));
    assign accept     = !start && card_ready && card_valid && (card_value != '0);
    assign hard_nxt   = start ? '0 : accept ? hard + SUM_W'(card_value) : hard;
    assign count_nxt  = start ? '0 : accept ? card_count + CNT_W'(1) : card_count;
    assign cstate     = st;
    assign result     = res;

`ifdef SOFT_ACE_EN
    logic ace;
    assign ace_nxt = start ? 1'b0 : accept ? (ace || card_value == CARD_W'(1)) : ace;
    always_ff @(posedge clk or negedge rst)
        if (!rst) ace <= 1'b0;
        else ace <= ace_nxt;
`else
    assign ace_nxt = 1'b0;
`endif

    hand_score #(.SUM_W(SUM_W), .TARGET(TARGET)) u_score (
        .hard  (hard_nxt),
        .ace   (ace_nxt),
        .score (s_nxt)
    );

    always_comb begin
        st_nxt  = st;
        res_nxt = res;
        if (start) begin
            st_nxt  = DRAW;
            res_nxt = RES_NONE;
        end else begin
            case (st)
                IDLE: st_nxt = IDLE;
                DRAW: begin
                    if (accept && s_nxt == SUM_W'(TARGET)) begin
                        st_nxt  = CLEAR;
                        res_nxt = RES_CLEAR;
                    end else if (accept && s_nxt > SUM_W'(TARGET)) begin
                        st_nxt  = OVER;
                        res_nxt = RES_OVER;
                    end else if (stand || (accept && count_nxt == CNT_W'(MAX_CARDS))) begin
                        st_nxt  = SHORT;
                        res_nxt = RES_SHORT;
                    end
                end
                CLEAR, OVER, SHORT: st_nxt = IDLE;
                default: st_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st         <= IDLE;
            res        <= RES_NONE;
            hard       <= '0;
            sum        <= '0;
            card_count <= '0;
            done       <= 1'b0;
        end else begin
            st         <= st_nxt;
            res        <= res_nxt;
            hard       <= hard_nxt;
            sum        <= s_nxt;
            card_count <= count_nxt;
            done       <= st_nxt inside {CLEAR, OVER, SHORT};
        end
    end
endmodule

// File: tb/tb_hand_evaluator.sv
// tb_hand_evaluator: directed self-checking bench for hand_evaluator at default parameters.
module tb_hand_evaluator;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       card_valid = 1'b0;
    logic [3:0] card_value = 4'd0;
    logic       stand = 1'b0;
    logic       card_ready;
    logic [2:0] cstate;
    logic [6:0] sum;
    logic [2:0] card_count;
    logic       done;
    logic [1:0] result;

    int total = 0;
    int passed = 0;

    hand_evaluator dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .card_valid (card_valid),
        .card_value (card_value),
        .stand      (stand),
        .card_ready (card_ready),
        .cstate     (cstate),
        .sum        (sum),
        .card_count (card_count),
        .done       (done),
        .result     (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic cyc(input logic s, input logic v, input logic [3:0] val, input logic st);
        start      = s;
        card_valid = v;
        card_value = val;
        stand      = st;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int st, input int sm, input int cnt,
                           input int dn, input int res);
        chk({tag, ".cstate"}, 32'(cstate), st);
        chk({tag, ".sum"}, 32'(sum), sm);
        chk({tag, ".count"}, 32'(card_count), cnt);
        chk({tag, ".done"}, 32'(done), dn);
        chk({tag, ".result"}, 32'(result), res);
    endtask

    initial begin
        #3;
        chk_all("reset", 0, 0, 0, 0, 0);
        chk("reset.ready", 32'(card_ready), 0);
        #9 rst = 1'b1;

        // exact hit: 5+6+7
        cyc(1, 0, 0, 0);
        chk_all("s1.start", 1, 0, 0, 0, 0);
        chk("s1.ready", 32'(card_ready), 1);
        cyc(0, 1, 5, 0);
        chk_all("s1.c1", 1, 5, 1, 0, 0);
        cyc(0, 1, 6, 0);
        chk_all("s1.c2", 1, 11, 2, 0, 0);
        cyc(0, 1, 7, 0);
        chk_all("s1.c3", 2, 18, 3, 1, 2);
        cyc(0, 1, 3, 0);
        chk_all("s1.idle", 0, 18, 3, 0, 2);
        cyc(0, 1, 3, 0);
        chk_all("s1.hold", 0, 18, 3, 0, 2);

        // bust: 10+9
        cyc(1, 0, 0, 0);
        cyc(0, 1, 10, 0);
        cyc(0, 1, 9, 0);
        chk_all("s2.over", 3, 19, 2, 1, 3);
        cyc(0, 0, 0, 0);
        chk_all("s2.idle", 0, 19, 2, 0, 3);

        // max cards without reaching target
        cyc(1, 0, 0, 0);
        cyc(0, 1, 2, 0);
        cyc(0, 1, 3, 0);
        cyc(0, 1, 4, 0);
        chk_all("s3.c3", 1, 9, 3, 0, 0);
        chk("s3.ready3", 32'(card_ready), 1);
        cyc(0, 1, 5, 0);
        chk_all("s3.short", 4, 14, 4, 1, 1);
        chk("s3.ready4", 32'(card_ready), 0);
        cyc(0, 0, 0, 0);
        chk_all("s3.idle", 0, 14, 4, 0, 1);

        // zero card dropped, then card with stand
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        chk_all("s4.zero", 1, 0, 0, 0, 0);
        cyc(0, 1, 6, 1);
        chk_all("s4.stand", 4, 6, 1, 1, 1);
        cyc(0, 0, 0, 0);

        // stand with a card that reaches target scores CLEAR, not SHORT
        cyc(1, 0, 0, 0);
        cyc(0, 1, 9, 0);
        cyc(0, 1, 9, 1);
        chk_all("s5.standclr", 2, 18, 2, 1, 2);
        // start during a result state
        cyc(1, 0, 0, 0);
        chk_all("s5.restart", 1, 0, 0, 0, 0);

        // stand alone and start overriding a card
        cyc(0, 1, 3, 0);
        cyc(1, 1, 5, 0);
        chk_all("s6.startpri", 1, 0, 0, 0, 0);
        cyc(0, 1, 4, 0);
        cyc(0, 0, 0, 1);
        chk_all("s6.stand", 4, 4, 1, 1, 1);
        cyc(0, 0, 0, 0);

        // ace behaviour
        cyc(1, 0, 0, 0);
        cyc(0, 1, 1, 0);
        cyc(0, 1, 7, 0);
`ifdef SOFT_ACE_EN
        chk_all("s7.ace", 2, 18, 2, 1, 2);
`else
        chk_all("s7.ace", 1, 8, 2, 0, 0);
`endif

        // async reset mid-hand
        cyc(1, 0, 0, 0);
        cyc(0, 1, 9, 0);
        chk("s8.pre", 32'(sum), 9);
        #2 rst = 1'b0;
        #1;
        chk_all("s8.rst", 0, 0, 0, 0, 0);
        chk("s8.ready", 32'(card_ready), 0);
        #2 rst = 1'b1;
        cyc(0, 1, 5, 0);
        chk_all("s8.idlecard", 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 1, 5, 0);
        chk_all("s8.after", 1, 5, 1, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
